mdu_seq: RTL

//  Iterative RV32M multiply/divide sequencer. Launched from the execute stage with both operands.

---
 rtl/mdu_seq_pkg.sv | 50 +++++
 rtl/mdu_div_step.sv | 35 +++
 rtl/mdu_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mdu_seq_pkg                                                      |
// | Purpose : Shared encodings for the iterative RV32M multiply/divide unit:   |
// |           funct3 operation codes, FSM state type and small op decoders.    |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mdu_seq_pkg;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU) ||
           (op == MDU_OP_REM) || (op == MDU_OP_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_REM) || (op == MDU_OP_REMU);
  endfunction

  // Operand A is treated as signed for everything except the *U forms.
  // MUL low half is sign-agnostic, so treating it as signed is harmless.
  function automatic logic op_signed_a(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_MUL) || (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
           (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_MUL) || (op == MDU_OP_MULH) ||
           (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mdu_div_step                                                     |
// | Purpose : One combinational restoring-division step. Shifts the next       |
// |           dividend bit into the partial remainder and subtracts the        |
// |           divisor when it fits.                                            |
// | Ports   : rem_i     [XLEN:0]   current partial remainder                   |
// |           divisor_i [XLEN-1:0] divisor magnitude                           |
// |           bit_i                next dividend bit (MSB first)               |
// |           rem_o     [XLEN:0]   new partial remainder                       |
// |           q_o                  quotient bit produced by this step          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted_w;
  logic [XLEN+1:0] diff_w;

  assign shifted_w = {rem_i, bit_i};
  assign diff_w    = shifted_w - {2'b00, divisor_i};

  // A clear top bit means no borrow: the divisor fit, so keep the difference.
  assign q_o   = ~diff_w[XLEN+1];
  assign rem_o = q_o ? diff_w[XLEN:0] : shifted_w[XLEN:0];

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mdu_seq                                                          |
// | Purpose : Iterative RV32M multiply/divide sequencer. Shift-add multiply or |
// |           restoring divide, one bit per cycle, with a held result and a    |
// |           one-cycle done pulse. busy_o stalls the decode stage.            |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           start_i, op_i[2:0], rs1_i, rs2_i : launch request and operands   |
// |           flush_i                          : abort in-flight operation     |
// |           busy_o (comb), done_o, result_o (registered)                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [MDU_OP_WIDTH-1:0] op_i,
  input  logic [XLEN-1:0]         rs1_i,
  input  logic [XLEN-1:0]         rs2_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         result_o
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mdu_state_e              state_q, state_d;
  logic [MDU_OP_WIDTH-1:0] op_q, op_d;
  logic                    neg_q, neg_d;
  logic [XLEN-1:0]         a_q, a_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic [XLEN:0]           rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic                    done_q, done_d;

  // ---------------- launch-time operand conditioning ----------------
  logic            sa_w, sb_w;
  logic [XLEN-1:0] abs_a_w, abs_b_w;
  logic            div_zero_w, div_ovf_w, special_w;
  logic [XLEN-1:0] special_res_w;

  assign sa_w    = op_signed_a(op_i) & rs1_i[XLEN-1];
  assign sb_w    = op_signed_b(op_i) & rs2_i[XLEN-1];
  assign abs_a_w = sa_w ? -rs1_i : rs1_i;
  assign abs_b_w = sb_w ? -rs2_i : rs2_i;

  assign div_zero_w = (rs2_i == '0);
  assign div_ovf_w  = ((op_i == MDU_OP_DIV) || (op_i == MDU_OP_REM)) &&
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign special_w  = op_is_div(op_i) && (div_zero_w || div_ovf_w);

  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = dividend (most negative), remainder = 0.
  assign special_res_w = div_zero_w ? (op_is_rem(op_i) ? rs1_i : {XLEN{1'b1}})
                                    : (op_is_rem(op_i) ? {XLEN{1'b0}} : rs1_i);

  // ---------------- per-cycle datapath step ----------------
  logic [XLEN:0]     mul_sum_w;
  logic [2*XLEN-1:0] mul_next_w, div_next_w, acc_step_w;
  logic [XLEN:0]     div_rem_w;
  logic              div_q_w;

  // Accumulator holds {partial product, remaining multiplier bits}; the
  // multiplier LSB decides the add, then everything shifts right one place.
  assign mul_sum_w  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign mul_next_w = {mul_sum_w, acc_q[XLEN-1:1]};

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i    (rem_q),
    .divisor_i(b_q),
    .bit_i    (acc_q[XLEN-1]),
    .rem_o    (div_rem_w),
    .q_o      (div_q_w)
  );

  // Low half shifts dividend bits out of the top and quotient bits in at the bottom.
  assign div_next_w = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_q_w};
  assign acc_step_w = op_is_div(op_q) ? div_next_w : mul_next_w;

  // Sign-corrected result from the values produced by the final step, so
  // result_o is already valid in the FIN cycle alongside done_o.
  logic [2*XLEN-1:0] prod_w;
  logic [XLEN-1:0]   quo_w, remv_w, final_w;

  assign prod_w = neg_q ? -acc_step_w : acc_step_w;
  assign quo_w  = neg_q ? -acc_step_w[XLEN-1:0] : acc_step_w[XLEN-1:0];
  assign remv_w = neg_q ? -div_rem_w[XLEN-1:0] : div_rem_w[XLEN-1:0];

  assign final_w = op_is_rem(op_q)      ? remv_w :
                   op_is_div(op_q)      ? quo_w  :
                   (op_q == MDU_OP_MUL) ? prod_w[XLEN-1:0] : prod_w[2*XLEN-1:XLEN];

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = abs_a_w;
          b_d   = abs_b_w;
          rem_d = '0;
          cnt_d = '0;
          if (op_is_div(op_i)) begin
            acc_d = {{XLEN{1'b0}}, abs_a_w};
            neg_d = op_is_rem(op_i) ? sa_w : (sa_w ^ sb_w);
          end else begin
            acc_d = {{XLEN{1'b0}}, abs_b_w};
            neg_d = sa_w ^ sb_w;
          end
          if (special_w) begin
            result_d = special_res_w;
            done_d   = 1'b1;
            state_d  = MDU_FIN;
          end else begin
            state_d  = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_d = acc_step_w;
        if (op_is_div(op_q)) begin
          rem_d = div_rem_w;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          result_d = final_w;
          done_d   = 1'b1;
          state_d  = MDU_FIN;
        end
      end
      MDU_FIN: begin
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase

    // Kill wins over everything: no completion, result stays as it was.
    if (flush_i) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Low in FIN so decode releases in the same cycle done_o is seen.
  assign busy_o   = (start_i && (state_q == MDU_IDLE)) || (state_q == MDU_CALC);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire
